ni_chan_rx_ring: RTL and testbench
==================================

// Module: ni_chan_rx_ring
// PURPOSE
//  - Multi-channel receive buffer for the NI: replaces a single fixed input memory with CHn independent circular FIFOs.
//  - NoC-side receive logic pushes words over a valid/ready stream tagged by channel.
//  - CPU pops words and manages per-channel thresholds, flush and irq through one Wishbone slave.
//  - Sits between the NI receive datapath and the processor bus.
// PARAMETERS
//  CHn     2    number of channels (>=2); CHw = log2(CHn)
//  Dw      32   data word width
//  Aw      8    per-channel depth = 2**Aw words; count width = Aw+1
//  S_Aw    7    Wishbone slave address width (word addressed); must be >= CHw+3
//  SELw    4    Wishbone byte-select width (ignored, full-word access only)
//  TAGw    3    Wishbone cti width (ignored, classic single-beat only)
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-low reset
//  in_valid     in   1       push request
//  in_ch        in   CHw     target channel of push
//  in_dat       in   Dw      push data
//  in_ready     out  1       = !full[in_ch]; push accepted when in_valid & in_ready
//  s_dat_i      in   Dw      wb write data
//  s_sel_i      in   SELw    wb byte select
//  s_addr_i     in   S_Aw    wb address
//  s_cti_i      in   TAGw    wb cycle type
//  s_stb_i      in   1       wb strobe
//  s_cyc_i      in   1       wb cycle
//  s_we_i       in   1       wb write enable
//  s_dat_o      out  Dw      wb read data
//  s_ack_o      out  1       wb acknowledge
//  irq          out  1       OR of per-channel irq, registered
// BEHAVIOUR
//  - Reset: all rd/wr pointers, counts and thresholds = 0; irq_en = 0; sticky bits = 0.
//    s_ack_o = 0; s_dat_o = 0; irq = 0; in_ready = 1 (all empty).
//  - Storage: one sync-read RAM of CHn*2**Aw words, address {ch, ptr[Aw-1:0]}. Pointers wrap modulo 2**Aw.
//  - full[ch]: count == 2**Aw. empty[ch]: count == 0.
//  - Push: wr_ptr+1, count+1.
//  - Push and pop on the same channel in the same cycle: count unchanged, both pointers advance.
//  - Wishbone FSM:
//    - IDLE: stb&cyc -> ACK, access performed on this edge.
//    - ACK: s_ack_o=1 for exactly one cycle, then IDLE.
//    - Latency: ack 1 cycle after stb; back-to-back accesses give ack every 2nd cycle.
//  - Address map, addr[S_Aw-1:CHw+3] ignored:
//    - addr[CHw+2]=0: data window, ch=addr[CHw+1:2]. Read pops one word.
//      - Pop from empty: returns 0, no pointer change, sets sticky UNF[ch].
//      - Write to the data window: acked, no effect.
//    - addr[CHw+2]=1: registers, ch=addr[CHw+1:2], reg=addr[1:0]:
//      - 0 COUNT (RO): {0, count}.
//      - 1 THRESH (RW): Aw+1 bits.
//      - 2 CTRL:
//        - bit0 irq_en RW.
//        - bit1 FLUSH, write 1 self-clears.
//        - bit8 UNF sticky, W1C.
//        - bit9 OVF sticky, W1C; set when in_valid & !in_ready for ch.
//      - 3 STATS (see CONFIGURATION).
//  - Flush takes effect on the IDLE->ACK edge: ptrs and count of ch = 0.
//    A push to that channel accepted on the same edge is discarded.
//  - irq_ch = irq_en & (THRESH != 0) & (count >= THRESH).
//    irq = registered OR of irq_ch, so 1 cycle after the condition.
//  - in_ready is combinational from count; never depends on Wishbone inputs.
// CONFIGURATION
//  NI_RX_RING_STATS_EN defined:
//    - per-channel 16-bit saturating counter of accepted pushes.
//    - Read at reg 3; any write to reg 3 clears it; flush also clears it.
//  Not defined:
//    - reg 3 reads 0, writes ignored; no counter flops.
// TESTING
//  1. Reset, push 0x11,0x22,0x33 to ch1, pop ch1 x3 -> 0x11,0x22,0x33; COUNT ch1 reads 3,2,1,0; ch0 untouched.
//  2. Fill ch0 with 2**Aw words -> in_ready=0 for in_ch=0, =1 for in_ch=1; extra push sets OVF ch0; no data lost.
//  3. Pop empty ch0 -> s_dat_o=0, UNF=1; write CTRL 0x100 -> UNF=0.
//  4. THRESH ch1=4, irq_en=1, push 4 words -> irq=1 one cycle after 4th push; pop 1 -> irq=0.
//  5. Simultaneous push+pop on ch0 at count=5 -> count stays 5, FIFO order kept; wrap test with 3*2**Aw words streamed.
//  6. Drop reset mid-stream with count=7 -> count=0, irq=0, s_ack_o=0 immediately (async); STATS=0 when NI_RX_RING_STATS_EN is defined.

Source files
------------

// File: rtl/ni_chan_rx_ring.sv
// rtl/ni_chan_rx_ring.sv - multi-channel receive ring buffer with Wishbone CPU access
//
// Purpose: CHn independent circular FIFOs sharing one sync-read RAM. The NoC
// receive path pushes tagged words over a valid/ready stream; the CPU pops
// words and manages per-channel threshold, flush, sticky error bits and irq
// through a classic single-beat Wishbone slave.
//
// Optional feature macro: NI_RX_RING_STATS_EN (per-channel 16-bit saturating
// count of accepted pushes, visible at register 3).
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   in_valid/in_ch/in_dat   push stream (channel-tagged)
//   in_ready                push acceptance, combinational from channel count
//   s_dat_i/s_sel_i/s_addr_i/s_cti_i/s_stb_i/s_cyc_i/s_we_i   Wishbone request
//   s_dat_o/s_ack_o         Wishbone response
//   irq                     registered OR of per-channel interrupt conditions

module ni_chan_rx_ring #(
    parameter int CHn  = 2,
    parameter int Dw   = 32,
    parameter int Aw   = 8,
    parameter int S_Aw = 7,
    parameter int SELw = 4,
    parameter int TAGw = 3,
    localparam int CHw = (CHn > 1) ? $clog2(CHn) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [CHw-1:0]  in_ch,
    input  logic [Dw-1:0]   in_dat,
    output logic            in_ready,
    input  logic [Dw-1:0]   s_dat_i,
    input  logic [SELw-1:0] s_sel_i,
    input  logic [S_Aw-1:0] s_addr_i,
    input  logic [TAGw-1:0] s_cti_i,
    input  logic            s_stb_i,
    input  logic            s_cyc_i,
    input  logic            s_we_i,
    output logic [Dw-1:0]   s_dat_o,
    output logic            s_ack_o,
    output logic            irq
);

    localparam int DEPTH = 1 << Aw;
    localparam logic [Aw:0] FULL = {1'b1, {Aw{1'b0}}};

    typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} wb_state_t;

    wb_state_t      state_q, state_d;
    logic           irq_q, irq_d;
    logic           pop_hit_q, pop_hit_d;
    logic [Dw-1:0]  reg_dat_q, reg_dat_d;
    logic [Dw-1:0]  rd_word_q;

    logic [Aw-1:0]  wr_ptr_q [CHn];
    logic [Aw-1:0]  wr_ptr_d [CHn];
    logic [Aw-1:0]  rd_ptr_q [CHn];
    logic [Aw-1:0]  rd_ptr_d [CHn];
    logic [Aw:0]    cnt_q    [CHn];
    logic [Aw:0]    cnt_d    [CHn];
    logic [Aw:0]    thr_q    [CHn];
    logic [Aw:0]    thr_d    [CHn];
    logic [CHn-1:0] irq_en_q, irq_en_d;
    logic [CHn-1:0] unf_q, unf_d;
    logic [CHn-1:0] ovf_q, ovf_d;
`ifdef NI_RX_RING_STATS_EN
    logic [15:0]    stats_q  [CHn];
    logic [15:0]    stats_d  [CHn];
`endif

    logic [Dw-1:0]  mem [0:CHn*DEPTH-1];

    // Request decode
    logic           acc;
    logic           is_reg;
    logic [CHw-1:0] wb_ch;
    logic [1:0]     reg_sel;
    logic           pop_req, pop_ok, reg_wr, reg_rd, flush_req;
    logic           push_ok, push_keep;

    assign acc       = (state_q == ST_IDLE) && s_stb_i && s_cyc_i;
    assign is_reg    = s_addr_i[CHw+2];
    assign wb_ch     = s_addr_i[CHw+1:2];
    assign reg_sel   = s_addr_i[1:0];
    assign pop_req   = acc && !s_we_i && !is_reg;
    assign pop_ok    = pop_req && (cnt_q[wb_ch] != '0);
    assign reg_wr    = acc && s_we_i && is_reg;
    assign reg_rd    = acc && !s_we_i && is_reg;
    assign flush_req = reg_wr && (reg_sel == 2'd2) && s_dat_i[1];

    assign in_ready  = (cnt_q[in_ch] != FULL);
    assign push_ok   = in_valid && in_ready;
    // A push landing on the same edge as a flush of its channel is dropped.
    assign push_keep = push_ok && !(flush_req && (wb_ch == in_ch));

    logic unused_bits;
    assign unused_bits = ^{s_sel_i, s_cti_i, s_addr_i, s_dat_i};

    // Storage: write and read ports never collide on a live word, since the
    // read pointer equals the write pointer only when empty or full.
    always_ff @(posedge clk) begin
        if (push_keep) begin
            mem[{in_ch, wr_ptr_q[in_ch]}] <= in_dat;
        end
        if (pop_ok) begin
            rd_word_q <= mem[{wb_ch, rd_ptr_q[wb_ch]}];
        end
    end

    always_comb begin
        state_d   = state_q;
        pop_hit_d = 1'b0;
        reg_dat_d = '0;
        irq_d     = 1'b0;
        irq_en_d  = irq_en_q;
        unf_d     = unf_q;
        ovf_d     = ovf_q;
        for (int c = 0; c < CHn; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            cnt_d[c]    = cnt_q[c];
            thr_d[c]    = thr_q[c];
`ifdef NI_RX_RING_STATS_EN
            stats_d[c]  = stats_q[c];
`endif
        end

        case (state_q)
            ST_IDLE: if (acc) state_d = ST_ACK;
            default: state_d = ST_IDLE;
        endcase

        pop_hit_d = pop_ok;
        if (reg_rd) begin
            case (reg_sel)
                2'd0: reg_dat_d = Dw'(cnt_q[wb_ch]);
                2'd1: reg_dat_d = Dw'(thr_q[wb_ch]);
                2'd2: begin
                    reg_dat_d[0] = irq_en_q[wb_ch];
                    reg_dat_d[8] = unf_q[wb_ch];
                    reg_dat_d[9] = ovf_q[wb_ch];
                end
                default: begin
`ifdef NI_RX_RING_STATS_EN
                    reg_dat_d = Dw'(stats_q[wb_ch]);
`endif
                end
            endcase
        end

        for (int c = 0; c < CHn; c++) begin
            logic inc, dec, sel;
            sel = (wb_ch == CHw'(c));
            inc = push_keep && (in_ch == CHw'(c));
            dec = pop_ok && sel;
            if (inc) wr_ptr_d[c] = wr_ptr_q[c] + Aw'(1);
            if (dec) rd_ptr_d[c] = rd_ptr_q[c] + Aw'(1);
            cnt_d[c] = cnt_q[c] + {{Aw{1'b0}}, inc} - {{Aw{1'b0}}, dec};
`ifdef NI_RX_RING_STATS_EN
            if (inc && (stats_q[c] != 16'hffff)) stats_d[c] = stats_q[c] + 16'd1;
`endif
            if (pop_req && sel && (cnt_q[c] == '0)) unf_d[c] = 1'b1;

            if (reg_wr && sel) begin
                case (reg_sel)
                    2'd1: thr_d[c] = s_dat_i[Aw:0];
                    2'd2: begin
                        irq_en_d[c] = s_dat_i[0];
                        if (s_dat_i[8]) unf_d[c] = 1'b0;
                        if (s_dat_i[9]) ovf_d[c] = 1'b0;
                        if (s_dat_i[1]) begin
                            wr_ptr_d[c] = '0;
                            rd_ptr_d[c] = '0;
                            cnt_d[c]    = '0;
`ifdef NI_RX_RING_STATS_EN
                            stats_d[c]  = '0;
`endif
                        end
                    end
                    2'd3: begin
`ifdef NI_RX_RING_STATS_EN
                        stats_d[c] = '0;
`endif
                    end
                    default: ;
                endcase
            end

            // A new overflow wins over a simultaneous W1C of the same bit.
            if (in_valid && !in_ready && (in_ch == CHw'(c))) ovf_d[c] = 1'b1;

            if (irq_en_q[c] && (thr_q[c] != '0) && (cnt_q[c] >= thr_q[c])) irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
            pop_hit_q <= 1'b0;
            reg_dat_q <= '0;
            irq_en_q  <= '0;
            unf_q     <= '0;
            ovf_q     <= '0;
            for (int c = 0; c < CHn; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
                thr_q[c]    <= '0;
`ifdef NI_RX_RING_STATS_EN
                stats_q[c]  <= '0;
`endif
            end
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            pop_hit_q <= pop_hit_d;
            reg_dat_q <= reg_dat_d;
            irq_en_q  <= irq_en_d;
            unf_q     <= unf_d;
            ovf_q     <= ovf_d;
            for (int c = 0; c < CHn; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
                thr_q[c]    <= thr_d[c];
`ifdef NI_RX_RING_STATS_EN
                stats_q[c]  <= stats_d[c];
`endif
            end
        end
    end

    assign s_ack_o = (state_q == ST_ACK);
    assign s_dat_o = !s_ack_o ? '0 : (pop_hit_q ? rd_word_q : reg_dat_q);
    assign irq     = irq_q;

endmodule

// File: tb/tb_ni_chan_rx_ring.sv
// tb/tb_ni_chan_rx_ring.sv - scoreboard bench for ni_chan_rx_ring with queue-based reference model

module tb_ni_chan_rx_ring;

    localparam int CHn   = 2;
    localparam int Dw    = 32;
    localparam int Aw    = 8;
    localparam int S_Aw  = 7;
    localparam int SELw  = 4;
    localparam int TAGw  = 3;
    localparam int CHw   = 1;
    localparam int DEPTH = 1 << Aw;

    logic            clk, reset;
    logic            in_valid;
    logic [CHw-1:0]  in_ch;
    logic [Dw-1:0]   in_dat;
    logic            in_ready;
    logic [Dw-1:0]   s_dat_i;
    logic [SELw-1:0] s_sel_i;
    logic [S_Aw-1:0] s_addr_i;
    logic [TAGw-1:0] s_cti_i;
    logic            s_stb_i, s_cyc_i, s_we_i;
    logic [Dw-1:0]   s_dat_o;
    logic            s_ack_o;
    logic            irq;

    ni_chan_rx_ring #(.CHn(CHn), .Dw(Dw), .Aw(Aw), .S_Aw(S_Aw), .SELw(SELw), .TAGw(TAGw)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ch(in_ch), .in_dat(in_dat), .in_ready(in_ready),
        .s_dat_i(s_dat_i), .s_sel_i(s_sel_i), .s_addr_i(s_addr_i), .s_cti_i(s_cti_i),
        .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i), .s_we_i(s_we_i),
        .s_dat_o(s_dat_o), .s_ack_o(s_ack_o), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef logic [Dw-1:0] word_t;
    typedef struct { bit chk; word_t exp; } sb_t;

    word_t mq [CHn][$];
    int    thr_m   [CHn];
    bit    ien_m   [CHn];
    bit    unf_m   [CHn];
    bit    ovf_m   [CHn];
    int    stats_m [CHn];
    sb_t   sb [$];
    sb_t   mon_e;
    bit    cond_prev, irq_exp, irq_chk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CHn; c++) begin
            mq[c].delete();
            thr_m[c] = 0; ien_m[c] = 0; unf_m[c] = 0; ovf_m[c] = 0; stats_m[c] = 0;
        end
    endfunction

    function automatic bit irq_cond();
        for (int c = 0; c < CHn; c++)
            if (ien_m[c] && thr_m[c] != 0 && mq[c].size() >= thr_m[c]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [S_Aw-1:0] a_data(input int ch);
        return S_Aw'(ch << 2);
    endfunction

    function automatic logic [S_Aw-1:0] a_reg(input int ch, input int r);
        return S_Aw'((1 << (CHw + 2)) | (ch << 2) | r);
    endfunction

    // Applies one cycle's worth of push and bus access to the model; returns
    // the expected read data (pre-access state) and expected in_ready.
    task automatic model_step(input bit dp, input int pch, input word_t pd,
                              input bit dw, input bit we, input logic [S_Aw-1:0] a,
                              input word_t wd, output word_t exp, output bit rdy);
        int ch, fch;
        rdy = mq[pch].size() < DEPTH;
        exp = '0;
        fch = -1;
        if (dw) begin
            ch = int'(a[CHw+1:2]);
            if (!a[CHw+2]) begin
                if (!we) begin
                    if (mq[ch].size() > 0) exp = mq[ch].pop_front();
                    else unf_m[ch] = 1'b1;
                end
            end else if (!we) begin
                case (a[1:0])
                    2'd0: exp = word_t'(mq[ch].size());
                    2'd1: exp = word_t'(thr_m[ch]);
                    2'd2: exp = (word_t'(ovf_m[ch]) << 9) | (word_t'(unf_m[ch]) << 8) | word_t'(ien_m[ch]);
                    default: begin
`ifdef NI_RX_RING_STATS_EN
                        exp = word_t'(stats_m[ch]);
`else
                        exp = '0;
`endif
                    end
                endcase
            end else begin
                case (a[1:0])
                    2'd1: thr_m[ch] = int'(wd[Aw:0]);
                    2'd2: begin
                        ien_m[ch] = wd[0];
                        if (wd[8]) unf_m[ch] = 1'b0;
                        if (wd[9]) ovf_m[ch] = 1'b0;
                        if (wd[1]) fch = ch;
                    end
                    2'd3: stats_m[ch] = 0;
                    default: ;
                endcase
            end
        end
        if (fch >= 0) begin
            mq[fch].delete();
            stats_m[fch] = 0;
        end
        if (dp) begin
            if (rdy) begin
                if (pch != fch) begin
                    mq[pch].push_back(pd);
                    if (stats_m[pch] < 65535) stats_m[pch]++;
                end
            end else begin
                ovf_m[pch] = 1'b1;
            end
        end
    endtask

    task automatic op(input bit dp, input int pch, input word_t pd,
                      input bit dw, input bit we, input logic [S_Aw-1:0] a, input word_t wd);
        word_t exp;
        bit    rdy;
        @(posedge clk);
        #1;
        model_step(dp, pch, pd, dw, we, a, wd, exp, rdy);
        in_valid = dp;
        in_ch    = CHw'(pch);
        in_dat   = pd;
        s_stb_i  = dw;
        s_cyc_i  = dw;
        s_we_i   = we;
        s_addr_i = a;
        s_dat_i  = wd;
        s_sel_i  = 4'hf;
        if (dw) sb.push_back('{chk: !we, exp: exp});
        if (dp) begin
            #1;
            check("in_ready", 32'(in_ready), 32'(rdy));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s_stb_i  = 1'b0;
        s_cyc_i  = 1'b0;
        s_we_i   = 1'b0;
        if (dw) check("ack_latency", 32'(s_ack_o), 32'd1);
    endtask

    task automatic push(input int ch, input word_t d);
        op(1'b1, ch, d, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [S_Aw-1:0] a);
        op(1'b0, 0, '0, 1'b1, 1'b0, a, '0);
    endtask

    task automatic wr(input logic [S_Aw-1:0] a, input word_t d);
        op(1'b0, 0, '0, 1'b1, 1'b1, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cond_prev <= 1'b0;
            irq_exp   <= 1'b0;
        end else begin
            cond_prev <= irq_cond();
            irq_exp   <= cond_prev;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (irq_chk) check("irq", 32'(irq), 32'(irq_exp));
            if (s_ack_o) begin
                if (sb.size() == 0) begin
                    check("ack_unexpected", 32'(s_ack_o), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.chk) check("rdata", s_dat_o, mon_e.exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [S_Aw-1:0] ra;
        word_t wd;
        reset = 1'b0; irq_chk = 1'b0;
        in_valid = 1'b0; in_ch = '0; in_dat = '0;
        s_dat_i = '0; s_sel_i = '0; s_addr_i = '0; s_cti_i = '0;
        s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
        model_reset();
        #12;
        check("rst_ack", 32'(s_ack_o), 32'd0);
        check("rst_dat", s_dat_o, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        idle(2);
        #1;
        reset = 1'b1;
        irq_chk = 1'b1;

        // Basic FIFO order and count on ch1, ch0 untouched
        push(1, 32'h11); push(1, 32'h22); push(1, 32'h33);
        rd(a_reg(1, 0));
        for (int i = 0; i < 3; i++) begin
            rd(a_data(1));
            rd(a_reg(1, 0));
        end
        rd(a_reg(0, 0));

        // Fill ch0, check full/ready per channel, overflow sticky
        for (int i = 0; i < DEPTH; i++) push(0, word_t'(32'hA000 + i));
        @(posedge clk); #1;
        in_ch = 1'b0; #1;
        check("full_ready_ch0", 32'(in_ready), 32'd0);
        in_ch = 1'b1; #1;
        check("full_ready_ch1", 32'(in_ready), 32'd1);
        push(0, 32'hDEAD);
        rd(a_reg(0, 2));
        wr(a_reg(0, 2), 32'h200);
        rd(a_reg(0, 2));
        for (int i = 0; i < DEPTH; i++) rd(a_data(0));
        rd(a_reg(0, 0));

        // Underflow sticky and W1C
        rd(a_data(0));
        rd(a_reg(0, 2));
        wr(a_reg(0, 2), 32'h100);
        rd(a_reg(0, 2));

        // Threshold interrupt on ch1
        wr(a_reg(1, 1), 32'd4);
        wr(a_reg(1, 2), 32'd1);
        for (int i = 0; i < 4; i++) push(1, $urandom);
        idle(3);
        rd(a_data(1));
        idle(3);
        wr(a_reg(1, 2), 32'h302);
        wr(a_reg(1, 1), 32'd0);

        // Simultaneous push+pop at count 5, streaming 3*DEPTH words through wrap
        for (int i = 0; i < 5; i++) push(0, $urandom);
        for (int i = 0; i < 3 * DEPTH; i++) op(1'b1, 0, $urandom, 1'b1, 1'b0, a_data(0), '0);
        rd(a_reg(0, 0));
        for (int i = 0; i < 5; i++) rd(a_data(0));

        // Randomised mix, including ignored upper address bits
        for (int i = 0; i < 400; i++) begin
            ra = S_Aw'($urandom);
            wd = $urandom;
            if (ra[CHw+2] && ra[1:0] == 2'd1) wd = word_t'($urandom_range(0, 6));
            op(1'($urandom), int'($urandom_range(0, CHn - 1)), $urandom,
               1'($urandom), ($urandom_range(0, 3) == 0), ra, wd);
        end

        // Asynchronous reset mid-stream with count 7 and irq raised
        for (int c = 0; c < CHn; c++) begin
            wr(a_reg(c, 2), 32'h302);
            wr(a_reg(c, 1), 32'd0);
        end
        wr(a_reg(0, 1), 32'd5);
        wr(a_reg(0, 2), 32'd1);
        for (int i = 0; i < 7; i++) push(0, $urandom);
        idle(3);
        check("pre_reset_irq", 32'(irq), 32'd1);
        rd(a_reg(0, 0));
        @(negedge clk);
        #2;
        irq_chk = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_rst_ack", 32'(s_ack_o), 32'd0);
        check("async_rst_irq", 32'(irq), 32'd0);
        in_ch = 1'b0; #1;
        check("async_rst_ready", 32'(in_ready), 32'd1);
        idle(2);
        #1;
        reset = 1'b1;
        irq_chk = 1'b1;
        rd(a_reg(0, 0));
        rd(a_reg(0, 3));
        rd(a_reg(0, 2));
        rd(a_reg(0, 1));

        idle(4);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
